// File: rtl/warp_scheduler_pkg.sv
// ============================================================================
// warp_scheduler_pkg : shared warp-pipeline types (state broadcast, IMEM address)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

`ifndef WARP_SCHED_NUM_WARPS
`define WARP_SCHED_NUM_WARPS 4
`endif

package warp_scheduler_pkg;

   localparam int IMEM_ADDR_W = 8;

   typedef logic [IMEM_ADDR_W-1:0] instruction_memory_address_t;

   typedef enum logic [2:0] {
      WARP_IDLE    = 3'd0,
      WARP_FETCH   = 3'd1,
      WARP_DECODE  = 3'd2,
      WARP_REQUEST = 3'd3,
      WARP_WAIT    = 3'd4,
      WARP_EXECUTE = 3'd5,
      WARP_UPDATE  = 3'd6,
      WARP_DONE    = 3'd7
   } warp_state_t;

   function automatic logic warp_active(input warp_state_t s);
      return !(s == WARP_IDLE || s == WARP_DONE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/warp_scheduler_rr.sv
// ============================================================================
// rr_next_warp : combinational round-robin search starting after `current`
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_next_warp
   import warp_scheduler_pkg::*;
#(
   parameter int NUM_WARPS = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_WARPS-1:0] eligible,
   input  logic [IDX_W-1:0]     current,
   output logic                 found,
   output logic [IDX_W-1:0]     index
);

   // Walk offsets from farthest to nearest so the nearest eligible warp wins;
   // offset NUM_WARPS lands back on `current`, which is therefore checked last.
   always_comb begin : find
      int cand;
      cand  = 0;
      found = 1'b0;
      index = '0;
      for (int k = NUM_WARPS; k >= 1; k--) begin
         cand = (int'(current) + k) % NUM_WARPS;
         if (eligible[cand]) begin
            found = 1'b1;
            index = IDX_W'(cand);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/warp_scheduler.sv
// ============================================================================
// warp_scheduler : round-robin sequencer of the shared per-warp pipeline
// Optional watchdog: define WARP_SCHED_TIMEOUT_EN.  Revision 1.0 : initial
// ============================================================================
`default_nettype none

module warp_scheduler
   import warp_scheduler_pkg::*;
#(
   parameter int NUM_WARPS    = `WARP_SCHED_NUM_WARPS,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic                                              start,
   input  logic [NUM_WARPS-1:0]                              warp_launch_mask,
   output logic                                              fetch_req,
   output instruction_memory_address_t                       fetch_addr,
   input  logic                                              fetch_valid,
   input  logic                                              decoded_halt,
   input  logic                                              decoded_mem_access,
   input  logic                                              lsu_done,
   input  instruction_memory_address_t                       next_pc,
   output logic [((NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1)-1:0] current_warp,
   output warp_state_t                                       warp_state,
   output logic [NUM_WARPS-1:0]                              warp_enable,
   output logic                                              done,
   output logic                                              timeout_err
);

   localparam int IDX_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

   warp_state_t                 state_q, state_d;
   logic [IDX_W-1:0]            current_warp_q, current_warp_d;
   logic [NUM_WARPS-1:0]        running_q, running_d;
   logic [NUM_WARPS-1:0]        halted_q, halted_d;
   instruction_memory_address_t pc_q [NUM_WARPS];
   instruction_memory_address_t pc_d [NUM_WARPS];

   logic                        launch;
   logic                        timeout_hit;
   logic                        retire_halt;
   logic [NUM_WARPS-1:0]        cur_onehot;
   logic [NUM_WARPS-1:0]        sel_eligible;
   logic [IDX_W-1:0]            sel_current;
   logic                        sel_found;
   logic [IDX_W-1:0]            sel_index;

   assign launch     = start && !warp_active(state_q);
   assign cur_onehot = NUM_WARPS'(1) << current_warp_q;

`ifdef WARP_SCHED_TIMEOUT_EN
   localparam int CNT_W = ($clog2(WAIT_TIMEOUT + 1) > 8) ? $clog2(WAIT_TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_err_q, timeout_err_d;

   always_comb begin
      timeout_hit = ((state_q == WARP_FETCH && !fetch_valid) ||
                     (state_q == WARP_WAIT && decoded_mem_access && !lsu_done)) &&
                    (wait_cnt_q == CNT_W'(WAIT_TIMEOUT - 1));
   end

   always_comb begin
      wait_cnt_d = '0;
      if ((state_q == WARP_FETCH || state_q == WARP_WAIT) && state_d == state_q && !timeout_hit)
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      timeout_err_d = timeout_err_q;
      if (launch)
         timeout_err_d = 1'b0;
      else if (timeout_hit)
         timeout_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // A retiring warp that halts must not be picked again in the same cycle.
   assign retire_halt = (state_q == WARP_UPDATE && decoded_halt) || timeout_hit;

   always_comb begin
      sel_eligible = running_q & ~(halted_q | (retire_halt ? cur_onehot : '0));
      sel_current  = current_warp_q;
      if (!warp_active(state_q)) begin
         sel_eligible = warp_launch_mask;
         sel_current  = IDX_W'(NUM_WARPS - 1);
      end
   end

   rr_next_warp #(
      .NUM_WARPS (NUM_WARPS),
      .IDX_W     (IDX_W)
   ) u_rr (
      .eligible (sel_eligible),
      .current  (sel_current),
      .found    (sel_found),
      .index    (sel_index)
   );

   always_comb begin
      state_d        = state_q;
      current_warp_d = current_warp_q;
      running_d      = running_q;
      halted_d       = halted_q;
      pc_d           = pc_q;

      unique case (state_q)
         WARP_IDLE, WARP_DONE: begin
            if (start) begin
               running_d      = warp_launch_mask;
               halted_d       = '0;
               for (int i = 0; i < NUM_WARPS; i++) pc_d[i] = '0;
               current_warp_d = sel_found ? sel_index : '0;
               state_d        = sel_found ? WARP_FETCH : WARP_DONE;
            end
         end
         WARP_FETCH:   if (fetch_valid) state_d = WARP_DECODE;
         WARP_DECODE:  state_d = WARP_REQUEST;
         WARP_REQUEST: state_d = WARP_WAIT;
         WARP_WAIT:    if (!decoded_mem_access || lsu_done) state_d = WARP_EXECUTE;
         WARP_EXECUTE: state_d = WARP_UPDATE;
         WARP_UPDATE:  if (!decoded_halt) pc_d[current_warp_q] = next_pc;
         default:      state_d = WARP_IDLE;
      endcase

      if (state_q == WARP_UPDATE || timeout_hit) begin
         if (retire_halt) halted_d = halted_q | cur_onehot;
         if (sel_found) begin
            current_warp_d = sel_index;
            state_d        = WARP_FETCH;
         end else begin
            state_d        = WARP_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= WARP_IDLE;
         current_warp_q <= '0;
         running_q      <= '0;
         halted_q       <= '0;
         for (int i = 0; i < NUM_WARPS; i++) pc_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         current_warp_q <= current_warp_d;
         running_q      <= running_d;
         halted_q       <= halted_d;
         for (int i = 0; i < NUM_WARPS; i++) pc_q[i] <= pc_d[i];
      end
   end

   assign warp_state   = state_q;
   assign current_warp = current_warp_q;
   assign fetch_req    = (state_q == WARP_FETCH);
   assign fetch_addr   = pc_q[current_warp_q];
   assign warp_enable  = warp_active(state_q) ? cur_onehot : '0;
   assign done         = (state_q == WARP_DONE);

endmodule

`default_nettype wire

// File: tb/tb_warp_scheduler.sv
// ============================================================================
// tb_warp_scheduler : randomized self-checking bench with instruction-level model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_warp_scheduler;
   import warp_scheduler_pkg::*;

   localparam int NW = 4;
   localparam int TO = 16;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        start;
   logic [NW-1:0]               warp_launch_mask;
   logic                        fetch_req;
   instruction_memory_address_t fetch_addr;
   logic                        fetch_valid;
   logic                        decoded_halt;
   logic                        decoded_mem_access;
   logic                        lsu_done;
   instruction_memory_address_t next_pc;
   logic [1:0]                  current_warp;
   warp_state_t                 warp_state;
   logic [NW-1:0]               warp_enable;
   logic                        done;
   logic                        timeout_err;

   always #5 clk = ~clk;

   warp_scheduler #(.NUM_WARPS(NW), .WAIT_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .warp_launch_mask(warp_launch_mask),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
      .decoded_halt(decoded_halt), .decoded_mem_access(decoded_mem_access),
      .lsu_done(lsu_done), .next_pc(next_pc), .current_warp(current_warp),
      .warp_state(warp_state), .warp_enable(warp_enable), .done(done),
      .timeout_err(timeout_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Instruction-level model: per-warp PCs, run/halt sets, current warp.
   instruction_memory_address_t m_pc [NW];
   logic [NW-1:0] m_run, m_halt;
   int            m_cur;
   bit            m_done, m_terr;
   int            trace[$];

   function automatic int pick(input int from);
      for (int k = 1; k <= NW; k++) begin
         int w;
         w = (from + k) % NW;
         if (m_run[w] && !m_halt[w]) return w;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [NW-1:0] mask);
      int n;
      warp_launch_mask = mask;
      start = 1'b1;
      tick();
      start = 1'b0;
      warp_launch_mask = NW'($urandom);
      m_run = mask; m_halt = '0; m_terr = 1'b0;
      for (int i = 0; i < NW; i++) m_pc[i] = '0;
      trace.delete();
      n = pick(NW - 1);
      m_done = (n < 0);
      m_cur  = (n < 0) ? 0 : n;
   endtask

   task automatic check_done(input string tag);
      check_eq({tag, "_done"},  32'(done), 32'd1);
      check_eq({tag, "_state"}, 32'(warp_state), 32'(WARP_DONE));
      check_eq({tag, "_en"},    32'(warp_enable), 32'd0);
      check_eq({tag, "_freq"},  32'(fetch_req), 32'd0);
   endtask

   // ldel: WAIT cycles for a memory op (lsu_done on the last); <0 means never.
   task automatic do_instr(input int fdel, input bit mem, input int ldel,
                           input bit halt, input instruction_memory_address_t npc);
      int wl, nxt;
      trace.push_back(m_cur);
      check_eq("cur_warp",   32'(current_warp), 32'(m_cur));
      check_eq("fetch_addr", 32'(fetch_addr),   32'(m_pc[m_cur]));
      check_eq("timeout",    32'(timeout_err),  32'(m_terr));
      decoded_mem_access = mem; decoded_halt = halt; next_pc = npc;
      for (int k = 0; k <= fdel; k++) begin
         check_eq("st_fetch", 32'(warp_state), 32'(WARP_FETCH));
         check_eq("freq",     32'(fetch_req),  32'd1);
         check_eq("en_fetch", 32'(warp_enable), 32'd1 << m_cur);
         fetch_valid = (k == fdel);
         lsu_done = 1'($urandom);
         tick();
      end
      fetch_valid = 1'b0;
      check_eq("st_decode", 32'(warp_state), 32'(WARP_DECODE));
      check_eq("freq_off",  32'(fetch_req),  32'd0);
      if ($urandom_range(0, 3) == 0) begin
         start = 1'b1; warp_launch_mask = NW'($urandom);
      end
      tick();
      start = 1'b0;
      check_eq("st_request", 32'(warp_state), 32'(WARP_REQUEST));
      tick();
      wl = !mem ? 1 : (ldel < 0 ? TO : ldel);
      for (int k = 0; k < wl; k++) begin
         check_eq("st_wait", 32'(warp_state),  32'(WARP_WAIT));
         check_eq("en_wait", 32'(warp_enable), 32'd1 << m_cur);
         lsu_done = mem ? (k == ldel - 1) : 1'($urandom);
         tick();
      end
      lsu_done = 1'b0;
      if (mem && ldel < 0) begin
         m_halt[m_cur] = 1'b1;
         m_terr = 1'b1;
      end else begin
         check_eq("st_exec", 32'(warp_state), 32'(WARP_EXECUTE));
         lsu_done = 1'($urandom);
         tick();
         check_eq("st_update", 32'(warp_state), 32'(WARP_UPDATE));
         tick();
         lsu_done = 1'b0;
         if (halt) m_halt[m_cur] = 1'b1;
         else      m_pc[m_cur] = npc;
      end
      nxt = pick(m_cur);
      if (nxt < 0) m_done = 1'b1;
      else         m_cur = nxt;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            guard, cw;
      int            halt_at [NW];
      int            lim [NW];
      int            cnt [NW];
      logic [NW-1:0] mk;

      reset = 1'b1; start = 1'b0; warp_launch_mask = '0; fetch_valid = 1'b0;
      decoded_halt = 1'b0; decoded_mem_access = 1'b0; lsu_done = 1'b0; next_pc = '0;
      tick(); tick();
      reset = 1'b0;
      check_eq("rst_state", 32'(warp_state),   32'(WARP_IDLE));
      check_eq("rst_cur",   32'(current_warp), 32'd0);
      check_eq("rst_en",    32'(warp_enable),  32'd0);
      check_eq("rst_freq",  32'(fetch_req),    32'd0);
      check_eq("rst_done",  32'(done),         32'd0);
      check_eq("rst_terr",  32'(timeout_err),  32'd0);
      check_eq("rst_addr",  32'(fetch_addr),   32'd0);

      // Two warps, pc+1 each step; warp 0 halts at PC 3, warp 2 at PC 5.
      halt_at = '{3, 0, 5, 0};
      launch(4'b0101);
      guard = 0;
      while (!m_done && guard < 50) begin
         do_instr(0, 1'b0, 0, (32'(m_pc[m_cur]) == halt_at[m_cur]),
                  instruction_memory_address_t'(m_pc[m_cur] + 1));
         guard++;
      end
      check_eq("dir_len", 32'(trace.size()), 32'd10);
      check_eq("dir_seq0", 32'(trace[0]), 32'd0);
      check_eq("dir_seq1", 32'(trace[1]), 32'd2);
      check_eq("dir_seq2", 32'(trace[2]), 32'd0);
      check_eq("dir_seq3", 32'(trace[3]), 32'd2);
      check_eq("dir_seq8", 32'(trace[8]), 32'd2);
      check_done("dir");

      // Memory op held for 10 WAIT cycles on a single warp.
      launch(4'b0010);
      do_instr(0, 1'b1, 10, 1'b0, 8'h40);
      do_instr(1, 1'b0, 0, 1'b1, 8'h00);
      check_done("mem");

      // Empty launch mask goes straight to DONE.
      launch(4'b0000);
      check_done("zero");
      tick();
      check_done("zero_hold");

      // Reset in the middle of a memory WAIT.
      launch(4'b1111);
      decoded_mem_access = 1'b1; fetch_valid = 1'b1;
      tick();
      fetch_valid = 1'b0;
      tick(); tick();
      check_eq("pre_rst_wait", 32'(warp_state), 32'(WARP_WAIT));
      tick();
      reset = 1'b1; fetch_valid = 1'b1;
      tick();
      reset = 1'b0; fetch_valid = 1'b0; decoded_mem_access = 1'b0;
      check_eq("mid_rst_state", 32'(warp_state),  32'(WARP_IDLE));
      check_eq("mid_rst_en",    32'(warp_enable), 32'd0);
      check_eq("mid_rst_done",  32'(done),        32'd0);
      check_eq("mid_rst_cur",   32'(current_warp), 32'd0);
      launch(4'b1000);
      do_instr(0, 1'b0, 0, 1'b0, 8'h22);
      do_instr(0, 1'b0, 0, 1'b1, 8'h00);
      check_done("post_rst");

      // Randomized programs.
      for (int it = 0; it < 6; it++) begin
         mk = (it == 3) ? '0 : NW'($urandom);
         for (int w = 0; w < NW; w++) begin
            lim[w] = $urandom_range(0, 4);
            cnt[w] = 0;
         end
         launch(mk);
         guard = 0;
         while (!m_done && guard < 100) begin
            cw = m_cur;
            do_instr($urandom_range(0, 3), ($urandom % 2) == 1, $urandom_range(1, 6),
                     cnt[cw] == lim[cw], instruction_memory_address_t'($urandom));
            cnt[cw]++;
            guard++;
         end
         check_eq("rand_finished", 32'(m_done), 32'd1);
         check_done("rand");
      end

`ifdef WARP_SCHED_TIMEOUT_EN
      // Stalled LSU: watchdog retires warp 0 after TO WAIT cycles.
      launch(4'b0011);
      do_instr(0, 1'b1, -1, 1'b0, 8'h00);
      check_eq("to_err", 32'(timeout_err), 32'd1);
      do_instr(0, 1'b0, 0, 1'b1, 8'h00);
      check_done("to");
      check_eq("to_sticky", 32'(timeout_err), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
